pll_dyn_cfg_ctrl: RTL and testbench

PLL_DYN_CFG_CTRL -- requirements
Module: pll_dyn_cfg_ctrl

---
 rtl/pll_dyn_cfg_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_pll_dyn_cfg_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_dyn_cfg_ctrl.sv
// pll_dyn_cfg_ctrl: PLL lock-acquisition and dynamic divider reconfiguration controller.
// Pulses the PLL reset, qualifies the raw lock over a stability window, retries on
// timeout, relocks automatically after a lock loss, and swaps divider codes only
// while the PLL is held in reset.
module pll_dyn_cfg_ctrl #(
    parameter int               DIV_W        = 6,
    parameter logic [DIV_W-1:0] DEF_IDSEL    = '0,
    parameter logic [DIV_W-1:0] DEF_FBDSEL   = '0,
    parameter logic [DIV_W-1:0] DEF_ODSEL    = '0,
    parameter int               RST_HOLD     = 16,
    parameter int               LOCK_STABLE  = 256,
    parameter int               LOCK_TIMEOUT = 65536,
    parameter int               MAX_RETRY    = 3
) (
    input  logic             clkin,
    input  logic             resetn,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_idsel,
    input  logic [DIV_W-1:0] cfg_fbdsel,
    input  logic [DIV_W-1:0] cfg_odsel,
    output logic             pll_reset,
    output logic [DIV_W-1:0] pll_idsel,
    output logic [DIV_W-1:0] pll_fbdsel,
    output logic [DIV_W-1:0] pll_odsel,
    input  logic             pll_lock,
    output logic             locked,
    output logic             busy,
    output logic             fail,
    output logic [3:0]       retry_cnt,
    output logic [7:0]       loss_cnt
);

    localparam logic [2:0] S_RST_HOLD  = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_LOCKED    = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    // Counter widths leave room for the full terminal value so no counter can wrap.
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int STAB_W = $clog2(LOCK_STABLE + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_HOLD - 1);
    localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]        RETRY_LAST = 4'(MAX_RETRY);

    logic [1:0]        rst_sync_q;
    logic              lock_meta_q;
    logic              lock_s_q;
    logic              run;
    logic              xfer;

    logic [2:0]        state_q,     state_d;
    logic [HOLD_W-1:0] hold_q,      hold_d;
    logic [STAB_W-1:0] stab_q,      stab_d;
    logic [TMO_W-1:0]  tmo_q,       tmo_d;
    logic [3:0]        retry_q,     retry_d;
    logic [7:0]        loss_q,      loss_d;
    logic              pll_reset_q, pll_reset_d;
    logic              locked_q,    locked_d;
    logic              busy_q,      busy_d;
    logic              fail_q,      fail_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic [DIV_W-1:0]  idsel_q,     idsel_d;
    logic [DIV_W-1:0]  fbdsel_q,    fbdsel_d;
    logic [DIV_W-1:0]  odsel_q,     odsel_d;

    // Reset release synchronizer: assertion is immediate, release reaches the FSM two edges later.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run  = rst_sync_q[1];
    assign xfer = cfg_valid & cfg_ready_q;

    // Two-flop synchronizer for the PLL lock, which is asynchronous to clkin.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state logic; every output is computed here and registered below.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        stab_d      = stab_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        loss_d      = loss_q;
        pll_reset_d = pll_reset_q;
        locked_d    = locked_q;
        busy_d      = busy_q;
        fail_d      = fail_q;
        cfg_ready_d = cfg_ready_q;
        idsel_d     = idsel_q;
        fbdsel_d    = fbdsel_q;
        odsel_d     = odsel_q;

        if (run) begin
            case (state_q)
                S_RST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d     = S_WAIT_LOCK;
                        hold_d      = '0;
                        tmo_d       = '0;
                        pll_reset_d = 1'b0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = S_STABLE;
                        stab_d  = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        retry_d     = retry_q + 4'd1;
                        pll_reset_d = 1'b1;
                        hold_d      = '0;
                        if (retry_q + 4'd1 == RETRY_LAST) begin
                            state_d     = S_FAIL;
                            busy_d      = 1'b0;
                            fail_d      = 1'b1;
                            cfg_ready_d = 1'b1;
                        end else begin
                            state_d = S_RST_HOLD;
                        end
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end

                // The timeout counter is frozen here so a glitch resumes it rather than restarting it.
                S_STABLE: begin
                    if (!lock_s_q) begin
                        state_d = S_WAIT_LOCK;
                    end else if (stab_q == STAB_LAST) begin
                        state_d     = S_LOCKED;
                        locked_d    = 1'b1;
                        busy_d      = 1'b0;
                        cfg_ready_d = 1'b1;
                    end else begin
                        stab_d = stab_q + 1'b1;
                    end
                end

                // A transfer and a lock loss in the same cycle: load the codes and still count the loss.
                S_LOCKED: begin
                    if (xfer || !lock_s_q) begin
                        state_d     = S_RST_HOLD;
                        hold_d      = '0;
                        pll_reset_d = 1'b1;
                        busy_d      = 1'b1;
                        locked_d    = 1'b0;
                        cfg_ready_d = 1'b0;
                        retry_d     = '0;
                        if (xfer) begin
                            idsel_d  = cfg_idsel;
                            fbdsel_d = cfg_fbdsel;
                            odsel_d  = cfg_odsel;
                        end
                        if (!lock_s_q && (loss_q != 8'hFF)) begin
                            loss_d = loss_q + 8'd1;
                        end
                    end
                end

                S_FAIL: begin
                    if (xfer) begin
                        state_d     = S_RST_HOLD;
                        hold_d      = '0;
                        pll_reset_d = 1'b1;
                        busy_d      = 1'b1;
                        fail_d      = 1'b0;
                        cfg_ready_d = 1'b0;
                        retry_d     = '0;
                        idsel_d     = cfg_idsel;
                        fbdsel_d    = cfg_fbdsel;
                        odsel_d     = cfg_odsel;
                    end
                end

                default: begin
                    state_d     = S_RST_HOLD;
                    hold_d      = '0;
                    pll_reset_d = 1'b1;
                    busy_d      = 1'b1;
                    locked_d    = 1'b0;
                    fail_d      = 1'b0;
                    cfg_ready_d = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers, all returned to the reset state asynchronously.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_RST_HOLD;
            hold_q      <= '0;
            stab_q      <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            busy_q      <= 1'b1;
            fail_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
            idsel_q     <= DEF_IDSEL;
            fbdsel_q    <= DEF_FBDSEL;
            odsel_q     <= DEF_ODSEL;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stab_q      <= stab_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_reset_q <= pll_reset_d;
            locked_q    <= locked_d;
            busy_q      <= busy_d;
            fail_q      <= fail_d;
            cfg_ready_q <= cfg_ready_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign pll_reset  = pll_reset_q;
    assign pll_idsel  = idsel_q;
    assign pll_fbdsel = fbdsel_q;
    assign pll_odsel  = odsel_q;
    assign locked     = locked_q;
    assign busy       = busy_q;
    assign fail       = fail_q;
    assign retry_cnt  = retry_q;
    assign loss_cnt   = loss_q;

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Testbench for pll_dyn_cfg_ctrl with RST_HOLD=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, MAX_RETRY=3.
module tb_pll_dyn_cfg_ctrl;

    logic       clkin = 1'b0;
    logic       resetn = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [5:0] cfg_idsel = '0;
    logic [5:0] cfg_fbdsel = '0;
    logic [5:0] cfg_odsel = '0;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       pll_lock = 1'b0;
    logic       locked;
    logic       busy;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [5:0] id;
        logic [5:0] fb;
        logic [5:0] od;
        int         lock_dly;
        int         exp_hold;
        int         exp_lat;
    } vec_t;

    vec_t vecs[4];

    pll_dyn_cfg_ctrl #(
        .DIV_W(6), .RST_HOLD(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(100), .MAX_RETRY(3)
    ) dut (
        .clkin(clkin), .resetn(resetn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
        .pll_reset(pll_reset),
        .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .pll_lock(pll_lock), .locked(locked), .busy(busy), .fail(fail),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_pll_reset"}, pll_reset, 1);
        chk({nm, "_locked"}, locked, 0);
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_fail"}, fail, 0);
        chk({nm, "_cfg_ready"}, cfg_ready, 0);
        chk({nm, "_retry"}, retry_cnt, 0);
        chk({nm, "_loss"}, loss_cnt, 0);
        chk({nm, "_dividers"}, {pll_idsel, pll_fbdsel, pll_odsel}, 0);
    endtask

    // Counts samples (current one included) for which pll_reset stays at lvl.
    task automatic count_level(input logic lvl, input int maxc, output int n);
        n = 0;
        while (pll_reset === lvl && n < maxc) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_locked(input int maxc, output int n);
        n = 0;
        while (locked !== 1'b1 && n < maxc) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_unlocked(input int maxc, output int n);
        n = 0;
        while (locked !== 1'b0 && n < maxc) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_loss;

        vecs[0] = '{id: 6'd3,  fb: 6'd5,  od: 6'd8,  lock_dly: 10, exp_hold: 4, exp_lat: 11};
        vecs[1] = '{id: 6'd63, fb: 6'd0,  od: 6'd42, lock_dly: 0,  exp_hold: 4, exp_lat: 11};
        vecs[2] = '{id: 6'd1,  fb: 6'd2,  od: 6'd3,  lock_dly: 50, exp_hold: 4, exp_lat: 11};
        vecs[3] = '{id: 6'd0,  fb: 6'd63, od: 6'd63, lock_dly: 85, exp_hold: 4, exp_lat: 11};

        // Power-on reset: outputs must settle without a clock edge.
        #2 resetn = 1'b0;
        #1 check_reset_state("por");
        repeat (3) tick();
        check_reset_state("por_held");

        // Normal acquisition.
        resetn = 1'b1;
        count_level(1'b1, 20, n);
        chk("init_hold_window", (n >= 4 && n <= 6), 1);
        chk("init_busy_wait", busy, 1);
        repeat (10) tick();
        pll_lock = 1'b1;
        wait_locked(40, n);
        chk("acq_latency", n, 11);
        chk("acq_busy", busy, 0);
        chk("acq_retry", retry_cnt, 0);
        chk("acq_cfg_ready", cfg_ready, 1);
        chk("acq_pll_reset", pll_reset, 0);
        chk("acq_fail", fail, 0);

        // Reconfiguration vectors.
        foreach (vecs[i]) begin
            cfg_idsel  = vecs[i].id;
            cfg_fbdsel = vecs[i].fb;
            cfg_odsel  = vecs[i].od;
            cfg_valid  = 1'b1;
            tick();
            cfg_valid = 1'b0;
            pll_lock  = 1'b0;
            chk($sformatf("v%0d_cfg_ready", i), cfg_ready, 0);
            chk($sformatf("v%0d_idsel", i), pll_idsel, vecs[i].id);
            chk($sformatf("v%0d_fbdsel", i), pll_fbdsel, vecs[i].fb);
            chk($sformatf("v%0d_odsel", i), pll_odsel, vecs[i].od);
            chk($sformatf("v%0d_pll_reset", i), pll_reset, 1);
            chk($sformatf("v%0d_locked", i), locked, 0);
            chk($sformatf("v%0d_busy", i), busy, 1);
            count_level(1'b1, 20, n);
            chk($sformatf("v%0d_hold", i), n, vecs[i].exp_hold);
            repeat (vecs[i].lock_dly) tick();
            pll_lock = 1'b1;
            wait_locked(40, n);
            chk($sformatf("v%0d_lock_lat", i), n, vecs[i].exp_lat);
            chk($sformatf("v%0d_retry", i), retry_cnt, 0);
            chk($sformatf("v%0d_codes_kept", i), {pll_idsel, pll_fbdsel, pll_odsel},
                {vecs[i].id, vecs[i].fb, vecs[i].od});
        end

        // Offer ignored while busy, then a one-cycle glitch during STABLE.
        cfg_idsel = 6'd7; cfg_fbdsel = 6'd7; cfg_odsel = 6'd7;
        cfg_valid = 1'b1;
        tick();
        pll_lock = 1'b0;
        cfg_idsel = 6'd9; cfg_fbdsel = 6'd9; cfg_odsel = 6'd9;
        count_level(1'b1, 20, n);
        chk("busy_offer_ignored", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd7, 6'd7, 6'd7});
        chk("busy_cfg_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        pll_lock = 1'b1;
        repeat (7) tick();
        chk("glitch_pre_locked", locked, 0);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        wait_locked(40, n);
        chk("glitch_relock_lat", n, 11);
        chk("glitch_retry", retry_cnt, 0);
        chk("glitch_loss", loss_cnt, 0);

        // Lock loss and transfer in the same cycle.
        pll_lock = 1'b0;
        tick();
        tick();
        chk("loss_xfer_pre_locked", locked, 1);
        cfg_idsel = 6'd12; cfg_fbdsel = 6'd34; cfg_odsel = 6'd56;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("loss_xfer_codes", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd12, 6'd34, 6'd56});
        chk("loss_xfer_loss", loss_cnt, 1);
        chk("loss_xfer_locked", locked, 0);
        chk("loss_xfer_pll_reset", pll_reset, 1);
        count_level(1'b1, 20, n);
        chk("loss_xfer_hold", n, 4);
        pll_lock = 1'b1;
        wait_locked(40, n);
        chk("loss_xfer_relock", n, 11);

        // Repeated lock losses with automatic relock; loss count saturates.
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            wait_unlocked(10, n);
            if (i == 0) begin
                chk("loss_fall_lat", n, 3);
                chk("loss_fall_pll_reset", pll_reset, 1);
                chk("loss_fall_busy", busy, 1);
            end
            exp_loss = (i + 2 > 255) ? 255 : i + 2;
            chk($sformatf("loss_cnt_%0d", i), loss_cnt, exp_loss);
            count_level(1'b1, 20, n);
            if (i == 0) chk("loss_hold", n, 4);
            pll_lock = 1'b1;
            wait_locked(40, n);
            chk($sformatf("loss_relock_%0d", i), n, 11);
        end
        chk("loss_saturated", loss_cnt, 255);
        chk("loss_retry", retry_cnt, 0);

        // Timeouts until FAIL.
        cfg_idsel = 6'd2; cfg_fbdsel = 6'd4; cfg_odsel = 6'd6;
        cfg_valid = 1'b1;
        pll_lock = 1'b0;
        tick();
        cfg_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            count_level(1'b1, 20, n);
            chk($sformatf("tmo%0d_hold", k), n, 4);
            count_level(1'b0, 200, n);
            chk($sformatf("tmo%0d_low", k), n, 100);
            chk($sformatf("tmo%0d_retry", k), retry_cnt, k);
        end
        chk("fail_flag", fail, 1);
        chk("fail_pll_reset", pll_reset, 1);
        chk("fail_cfg_ready", cfg_ready, 1);
        chk("fail_busy", busy, 0);
        chk("fail_locked", locked, 0);
        repeat (5) tick();
        chk("fail_sticky", {fail, pll_reset, retry_cnt}, {1'b1, 1'b1, 4'd3});

        // Leave FAIL through a new configuration.
        cfg_idsel = 6'd1; cfg_fbdsel = 6'd1; cfg_odsel = 6'd1;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("unfail_fail", fail, 0);
        chk("unfail_retry", retry_cnt, 0);
        chk("unfail_codes", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd1, 6'd1, 6'd1});
        chk("unfail_cfg_ready", cfg_ready, 0);
        chk("unfail_busy", busy, 1);

        // Reset asserted mid-attempt, between clock edges.
        count_level(1'b1, 20, n);
        chk("mid_in_wait", pll_reset, 0);
        repeat (5) tick();
        #2 resetn = 1'b0;
        #1 check_reset_state("mid");
        tick();
        resetn = 1'b1;
        count_level(1'b1, 20, n);
        chk("rerun_hold_window", (n >= 4 && n <= 6), 1);
        repeat (3) tick();
        pll_lock = 1'b1;
        wait_locked(40, n);
        chk("rerun_lock_lat", n, 11);
        chk("rerun_loss", loss_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
